// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial word collector.
package serial_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned MAX_WIDTH     = 64;

  typedef enum logic {IDLE, SHIFT} state_e;

  // True when word is the most negative two's-complement value of the given width.
  function automatic logic is_min_word(input logic [MAX_WIDTH-1:0] word,
                                       input int unsigned width);
    logic [MAX_WIDTH-1:0] min_val;
    min_val = MAX_WIDTH'(1) << (width - 1);
    return word == min_val;
  endfunction

endpackage

// File: rtl/ser_word_hold.sv
// Single-entry valid/ready holding register; drops new data and flags overrun when full.
module ser_word_hold #(
  parameter int unsigned Width = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [Width-1:0] data_q;
  logic             valid_q;
  logic             overrun_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (wr_en_i) begin
      // A word retiring on the same edge frees the slot for the new one.
      if (!valid_q || ready_i) begin
        data_q  <= wr_data_i;
        valid_q <= 1'b1;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_word_collector.sv
// Reassembles LSB-first serial words into parallel values with framing and overrun detection.
module serial_word_collector
  import serial_pkg::*;
#(
  parameter  int unsigned WIDTH = DEFAULT_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             t_clk,
  input  logic             r,
  input  logic             s_bit,
  input  logic             s_sof,
  input  logic             s_valid,
  output logic [WIDTH-1:0] out_word,
  output logic             out_min,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overrun
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic             frame_err_q;

  logic             last_bit;
  logic             complete;
  logic [WIDTH-1:0] done_word;
  logic             done_min;
  logic [WIDTH:0]   hold_data;

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign complete = s_valid && (state_q == SHIFT) && !s_sof && last_bit;

  // The final bit bypasses the shift register so the word is offered on its own edge.
  always_comb begin
    done_word            = shreg_q;
    done_word[WIDTH-1]   = s_bit;
  end

  assign done_min = is_min_word(MAX_WIDTH'(done_word), WIDTH);

  always_ff @(posedge t_clk) begin
    if (r) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (s_valid) begin
        case (state_q)
          IDLE: begin
            if (s_sof) begin
              shreg_q[0] <= s_bit;
              cnt_q      <= CNT_W'(1);
              state_q    <= SHIFT;
            end
          end
          SHIFT: begin
            if (s_sof) begin
              frame_err_q <= 1'b1;
              shreg_q[0]  <= s_bit;
              cnt_q       <= CNT_W'(1);
            end else if (last_bit) begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              for (int i = 0; i < WIDTH; i++) begin
                if (cnt_q == CNT_W'(i)) shreg_q[i] <= s_bit;
              end
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  ser_word_hold #(
    .Width (WIDTH + 1)
  ) u_hold (
    .clk_i     (t_clk),
    .rst_i     (r),
    .wr_en_i   (complete),
    .wr_data_i ({done_min, done_word}),
    .ready_i   (out_ready),
    .data_o    (hold_data),
    .valid_o   (out_valid),
    .overrun_o (overrun)
  );

  assign out_word  = hold_data[WIDTH-1:0];
  assign out_min   = hold_data[WIDTH];
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed bench for serial_word_collector with a word-level reference model.
module tb_serial_word_collector;

  localparam int unsigned W = 8;

  logic         t_clk = 1'b0;
  logic         r = 1'b1;
  logic         s_bit = 1'b0;
  logic         s_sof = 1'b0;
  logic         s_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_word;
  logic         out_min;
  logic         out_valid;
  logic         frame_err;
  logic         overrun;

  serial_word_collector #(
    .WIDTH (W)
  ) dut (
    .t_clk     (t_clk),
    .r         (r),
    .s_bit     (s_bit),
    .s_sof     (s_sof),
    .s_valid   (s_valid),
    .out_word  (out_word),
    .out_min   (out_min),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 t_clk = ~t_clk;

  int n_vec = 0;
  int n_fail = 0;
  int fe_count = 0;
  logic [W-1:0] log_word[$];
  logic         log_min[$];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Word-level model: collect bits as an integer, then a one-slot output buffer.
  bit           m_in_word = 0;
  int           m_pos = 0;
  int unsigned  m_acc = 0;
  logic [W-1:0] m_word = '0;
  bit           m_valid = 0;
  bit           m_overrun = 0;
  bit           m_fe = 0;

  always @(posedge t_clk) begin
    bit done;
    done = 0;
    if (r) begin
      m_in_word = 0;
      m_pos     = 0;
      m_acc     = 0;
      m_word    = '0;
      m_valid   = 0;
      m_overrun = 0;
      m_fe      = 0;
    end else begin
      m_fe = 0;
      if (s_valid) begin
        if (s_sof) begin
          m_fe      = m_in_word;
          m_in_word = 1;
          m_pos     = 1;
          m_acc     = 32'(s_bit);
        end else if (m_in_word) begin
          m_acc = m_acc + (32'(s_bit) << m_pos);
          m_pos++;
          if (m_pos == W) begin
            done      = 1;
            m_in_word = 0;
          end
        end
      end
      if (done) begin
        if (!m_valid || out_ready) begin
          m_word  = W'(m_acc);
          m_valid = 1;
        end else begin
          m_overrun = 1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(posedge t_clk) begin
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_word", 32'(out_word), 32'(m_word));
    check("out_min", 32'(out_min), 32'(m_word == W'(1 << (W - 1))));
    check("frame_err", 32'(frame_err), 32'(m_fe));
    check("overrun", 32'(overrun), 32'(m_overrun));
    if (frame_err === 1'b1) fe_count++;
    #3;
    if (out_valid && out_ready) begin
      log_word.push_back(out_word);
      log_min.push_back(out_min);
    end
  end

  task automatic step(input logic b, input logic sof, input logic v);
    @(posedge t_clk);
    #2;
    s_bit   = b;
    s_sof   = sof;
    s_valid = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit stall);
    for (int i = 0; i < W; i++) begin
      if (stall) step(1'b0, 1'b0, 1'b0);
      step(w[i], i == 0, 1'b1);
    end
  endtask

  // Serial negator: copy bits through the first 1, invert every bit after it.
  task automatic send_negated(input logic [W-1:0] w);
    bit seen;
    seen = 0;
    for (int i = 0; i < W; i++) begin
      step(w[i] ^ seen, i == 0, 1'b1);
      seen = seen | w[i];
    end
  endtask

  logic [W-1:0] exp_words[8] = '{8'h05, 8'h80, 8'hFB, 8'h3C, 8'h11, 8'hA5, 8'h01, 8'hD3};

  initial begin
    repeat (2) @(posedge t_clk);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_word", 32'(out_word), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    r = 1'b0;

    send_word(8'h05, 0);
    idle(3);

    send_word(8'h80, 0);
    send_word(8'hFB, 0);
    idle(3);

    check("fe_before_t3", 32'(fe_count), 32'd0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    send_word(8'h3C, 0);
    idle(3);
    check("fe_pulses", 32'(fe_count), 32'd1);

    step(1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    idle(3);
    check("t4_held_word", 32'(out_word), 32'h11);
    check("t4_held_valid", 32'(out_valid), 32'h1);
    check("t4_overrun", 32'(overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    idle(3);
    check("t4_drained", 32'(out_valid), 32'h0);
    check("t4_sticky", 32'(overrun), 32'h1);
    check("t4_word_kept", 32'(out_word), 32'h11);
    step(1'b0, 1'b0, 1'b0);
    r = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    r = 1'b0;
    check("t4_rst_overrun", 32'(overrun), 32'h0);

    send_word(8'hA5, 1);
    idle(3);
    for (int i = 0; i < 6; i++) step(1'b1, i == 0, 1'b1);
    r = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    r = 1'b0;
    send_word(8'h01, 0);
    idle(3);

    send_negated(8'h2D);
    idle(4);

    check("log_count", 32'(log_word.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < log_word.size()) check($sformatf("log_word%0d", i), 32'(log_word[i]),
                                     32'(exp_words[i]));
    end
    if (log_min.size() >= 3) begin
      check("min_0x05", 32'(log_min[0]), 32'h0);
      check("min_0x80", 32'(log_min[1]), 32'h1);
      check("min_0xfb", 32'(log_min[2]), 32'h0);
    end
    check("fe_total", 32'(fe_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_word_collector.md
Name: serial_word_collector

Overview:
- Receive-side counterpart of the bit-serial two's-complement negator.
- Takes the negator's serial output (LSB first) plus an aligned word-start marker and reassembles each word into a parallel value.
- Presents the word on a valid/ready handshake with a negation-overflow flag, and detects framing errors and output overrun.
- Sits between the serial datapath and any parallel consumer; also serves as the bench's self-checking capture point.

Parameters:
- WIDTH, 8, bits per serial word (≥2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden).

Ports:
- t_clk  in  1  clock; all state changes on rising edge.
- r  in  1  reset, synchronous, active-high.
- s_bit  in  1  serial data bit, LSB first.
- s_sof  in  1  start-of-word; high with bit 0 of each word.
- s_valid  in  1  s_bit/s_sof meaningful this cycle; low = stall, no bit consumed.
- out_word  out  WIDTH  assembled word, bit k = k-th bit received.
- out_min  out  1  out_word == {1'b1, {WIDTH-1{1'b0}}} (negation overflowed).
- out_valid  out  1  out_word/out_min held valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- frame_err  out  1  one-cycle pulse on framing error.
- overrun  out  1  sticky; set when a completed word is dropped.

Behaviour:
- Reset (r=1 at edge): FSM→IDLE, bit counter=0, shift reg=0, out_word=0, out_min=0, out_valid=0, frame_err=0, overrun=0. Reset mid-word discards the partial word. Reset overrides every other input.
- FSM states IDLE, SHIFT. Only cycles with s_valid=1 are bit cycles.
- IDLE:
  - s_sof=1: bit → position 0, cnt=1, go to SHIFT.
  - s_sof=0: bit ignored; no error.
- SHIFT:
  - s_sof=0: bit → position cnt, cnt+1.
  - s_sof=1 with cnt<WIDTH: frame_err pulses next cycle; partial word discarded; this bit restarts as position 0, cnt=1.
- Completion: edge accepting position WIDTH-1 → FSM to IDLE. The word is offered to the holding register on that edge; out_valid rises the following cycle. Latency = 1 cycle after the last bit.
- Back-to-back: s_sof in the cycle right after the last bit is accepted normally (IDLE path). No dead cycle is required.
- WIDTH=1 degenerate case: not supported.
- Holding register (single entry):
  - Empty: loads the completed word, sets out_valid.
  - Full, and out_valid&out_ready in the same cycle as completion: old word retires, new word loads, out_valid stays 1, no overrun.
  - Full, not consumed: new word dropped, overrun←1. Stays set until r.
  - Consumed with no completion: out_valid←0. out_word holds its last value.
- out_min is computed from the completed word and registered with it.
- s_valid=0 holds all counters; the stall can occur mid-word without limit.

Decomposition:
- Package serial_pkg:
  - FSM enum {IDLE, SHIFT}.
  - default WIDTH constant.
  - min-value helper function used for out_min.
- One sub-module, ser_word_hold: the single-entry valid/ready holding register with overrun detection. Parameterised by WIDTH+1 (word + min flag).

Test Plan:
1. WIDTH=8, r=1 for 2 cycles, then stream 0x05 LSB first (1,0,1,0,0,0,0,0), s_sof on first bit, out_ready=1 → out_valid high one cycle after 8th bit, out_word=0x05, out_min=0, frame_err never high.
2. Stream 0x80 (0,0,0,0,0,0,0,1) → out_word=0x80, out_min=1. Stream 0xFB immediately after with no gap → second word 0xFB delivered; both accepted.
3. s_sof reasserted at bit 4 of a word, then a full 0x3C → frame_err one pulse; only 0x3C appears on out_word.
4. out_ready=0, send 0x11 then 0x22 → out_word stays 0x11, overrun=1. Raise out_ready → 0x11 accepted, out_valid falls, overrun stays 1 until r.
5. s_valid toggled 0/1 every other cycle during 0xA5 → out_word=0xA5. Also assert r after bit 5 of a word, then send 0x01 → no output for the aborted word; 0x01 delivered.
6. Chain the negator to the collector; input 0x2D serially with start marker → out_word=0xD3 (−0x2D mod 256).
